// File: rtl/reg_ab_pkg.sv
// Shared constants for the 8-bit bus CPU registers (A, B, PC, MAR, ALU out).
package reg_ab_pkg;

  localparam int DATA_W = 8;

endpackage

// File: rtl/bus_tristate.sv
// Enable-low tri-state driver onto the shared system bus.
module bus_tristate
  import reg_ab_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             en_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y
);

  // Released (all-Z) whenever not enabled so another source can own the bus.
  assign y = en_n ? {WIDTH{1'bz}} : d;

endmodule

// File: rtl/reg_ab_top.sv
// General-purpose bus register (A or B): loads from the bus on ai_n, drives it on ao_n,
// and always presents its value on A for the ALU.
module reg_ab_top
  import reg_ab_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ai_n,
  input  logic             ao_n,
  inout  wire [WIDTH-1:0]  bus,
  output logic [WIDTH-1:0] A
);

  logic [WIDTH-1:0] r;

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values;
  // clr_n sits in the sensitivity list so clearing does not wait for a clock edge.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r <= '0;
    end else if (!ai_n) begin
      r <= bus;
    end
  end

  assign A = r;

  // With ai_n and ao_n both low the register simply reloads its own value.
  bus_tristate #(.WIDTH(WIDTH)) u_bus_drv (
    .en_n (ao_n),
    .d    (r),
    .y    (bus)
  );

endmodule

// File: tb/tb_reg_ab_top.sv
// Directed self-checking bench for reg_ab_top: reset, load, hold, tri-state output.
module tb_reg_ab_top;

  logic       clk;
  logic       clr_n;
  logic       ai_n;
  logic       ao_n;
  logic       drv_en;
  logic [7:0] bus_drive;
  wire  [7:0] bus;
  logic [7:0] a_val;

  int n_checks = 0;
  int n_fail   = 0;

  assign bus = drv_en ? bus_drive : 8'bzzzzzzzz;

  reg_ab_top #(.WIDTH(8)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .ai_n  (ai_n),
    .ao_n  (ao_n),
    .bus   (bus),
    .A     (a_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  initial begin
    clr_n     = 1'b1;
    ai_n      = 1'b1;
    ao_n      = 1'b1;
    drv_en    = 1'b1;
    bus_drive = 8'h00;

    // Asynchronous reset well before the first rising edge at t=5.
    #2 clr_n = 1'b0;
    #1 check("reset_async_A", a_val, 8'h00);
    drv_en = 1'b0;
    #1 check("reset_bus_z", {7'b0, bus === 8'bzzzzzzzz}, 8'h01);
    ao_n = 1'b0;
    #0.5 check("reset_bus_driven_0", bus, 8'h00);
    ao_n   = 1'b1;
    drv_en = 1'b1;
    @(negedge clk);
    clr_n = 1'b1;

    // Load 0xAA.
    @(negedge clk);
    bus_drive = 8'hAA;
    ai_n      = 1'b0;
    @(posedge clk);
    #1 check("load_AA_after_edge", a_val, 8'hAA);
    @(negedge clk);
    ai_n = 1'b1;
    #20 check("load_AA_hold", a_val, 8'hAA);

    // Drive bus from register.
    drv_en = 1'b0;
    ao_n   = 1'b0;
    #1 check("out_bus_AA", bus, 8'hAA);
    check("out_A_AA", a_val, 8'hAA);
    ao_n = 1'b1;
    #1 check("out_release_z", {7'b0, bus === 8'bzzzzzzzz}, 8'h01);

    // Hold with 0x55 on bus across several edges.
    drv_en    = 1'b1;
    bus_drive = 8'h55;
    #1 check("bench_owns_bus", bus, 8'h55);
    repeat (3) @(posedge clk);
    #1 check("hold_A_AA", a_val, 8'hAA);

    // Self-reload: ai_n and ao_n low together.
    @(negedge clk);
    drv_en = 1'b0;
    ai_n   = 1'b0;
    ao_n   = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("selfload_A", a_val, 8'hAA);
    check("selfload_bus", bus, 8'hAA);

    // Boundary patterns.
    @(negedge clk);
    ao_n   = 1'b1;
    drv_en = 1'b1;
    foreach (bus_drive[i]) begin end
    bus_drive = 8'h01;
    @(posedge clk);
    #1 check("load_01", a_val, 8'h01);
    @(negedge clk);
    bus_drive = 8'h80;
    @(posedge clk);
    #1 check("load_80", a_val, 8'h80);
    @(negedge clk);
    bus_drive = 8'hFF;
    @(posedge clk);
    #1 check("load_FF", a_val, 8'hFF);

    // Load 0x3C then reset mid-load.
    @(negedge clk);
    bus_drive = 8'h3C;
    @(posedge clk);
    #1 check("load_3C", a_val, 8'h3C);
    #2 clr_n = 1'b0;
    #1 check("midload_reset_A", a_val, 8'h00);
    @(posedge clk);
    #1 check("reset_held_over_edge", a_val, 8'h00);
    @(negedge clk);
    bus_drive = 8'h5A;
    clr_n     = 1'b1;
    #1 check("reset_release_no_edge", a_val, 8'h00);
    @(posedge clk);
    #1 check("load_after_release", a_val, 8'h5A);

    // Output reflects new load immediately.
    @(negedge clk);
    ai_n   = 1'b1;
    drv_en = 1'b0;
    ao_n   = 1'b0;
    #1 check("out_bus_5A", bus, 8'h5A);
    ao_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
